panel_control_encoder: RTL and testbench
========================================

Name: panel_control_encoder

Overview:
- Front-panel input conditioner that produces the 15-bit controls word consumed by the high-level mode FSM.
- Synchronizes and debounces the raw labkit buttons, and converts presses into single-cycle select/enter pulses.
- Guarantees at most one select pulse per cycle, with an enter pulse never coincident with a select.
- Passes synchronized switch levels into the value and mode fields, and reports the current selection for LEDs.

Parameters:
- DEBOUNCE_CYCLES, 650000: consecutive stable cycles required before a button's debounced level changes (~24 ms at 27 MHz).
- SYNC_STAGES, 2: flip-flop synchronizer depth on every raw input (minimum 2).

Ports:
- clock  in  1: system clock.
- reset  in  1: asynchronous, active-high; clears all state.
- btn_f  in  1: raw button, select block F (active-high, bouncy).
- btn_t  in  1: raw button, select block T.
- btn_m  in  1: raw button, select block M.
- btn_enter  in  1: raw button, commit value.
- switch  in  10: raw switches; [7:0] value byte, [9:8] mode bits.
- controls  out  15: [7:0] value, [8] reserved 0, [9] sel M pulse, [10] sel T pulse, [11] sel F pulse, [12] enter pulse, [14:13] mode.
- active_sel  out  2: last issued selection; F=0, T=1, M=2.

Behaviour:
- Reset (async assert, sync use after deassert):
  - controls=0 and active_sel=0.
  - All synchronizer flops, debounced levels, counters and the pending-enter flag are cleared.
- Synchronizer: every button and switch bit passes through SYNC_STAGES flops.
- Debounce (buttons only):
  - Per button, a counter increments while the synchronized level differs from the debounced level, and clears to 0 on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
- Edge detect: a rise is the cycle in which the debounced level goes 0->1. Falls produce nothing.
- Latency from a clean raw edge to the registered pulse is SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Select pulses:
  - controls[11:9] are registered, one cycle wide, and one-hot or zero.
  - Priority when rises coincide: F > T > M. Lower-priority rises in that cycle are dropped, not deferred.
  - An issued select updates active_sel in the same cycle that the pulse is driven.
- Enter pulse:
  - controls[12] is one cycle wide and never asserted in the same cycle as any controls[11:9] bit.
  - If an enter rise coincides with a select pulse, set pending_enter. Emit enter in the first later cycle with no select pulse, then clear pending_enter.
  - A further enter rise while pending does not double-count; a single pulse is emitted.
- Level fields:
  - controls[7:0] = synchronized switch[7:0] and controls[14:13] = synchronized switch[9:8], registered every cycle with no debounce.
  - controls[8] is constant 0.
- Holding a button produces exactly one pulse; releasing it produces none.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse and no level change.
- Reset mid-debounce or while pending discards the partial count and the pending enter.
  - A button still held after reset release produces one pulse after the full latency.

Decomposition:
- Shared package panel_pkg:
  - Selection encodings SEL_F=2'd0, SEL_T=2'd1, SEL_M=2'd2.
  - Controls bit indices CTL_VAL_LSB=0, CTL_VAL_MSB=7, CTL_SEL_M=9, CTL_SEL_T=10, CTL_SEL_F=11, CTL_ENTER=12, CTL_MODE_LSB=13.
  - The same constants are also used by the mode FSM.
- Sub-module button_debouncer (parameters SYNC_STAGES, DEBOUNCE_CYCLES; outputs level and rise), instantiated once per button.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Top level holds the switch synchronizer, priority/pending logic, output registers and active_sel.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean btn_t 0->1 held 20 cycles: controls[10] high for exactly 1 cycle, 7 cycles after the edge; active_sel=1; no second pulse on hold or release.
- btn_f toggling every 2 cycles for 12 cycles, then held high: no pulse during bounce; one controls[11] pulse 7 cycles after it settles.
- btn_f and btn_m rise in the same cycle: only controls[11] pulses, active_sel=0; no controls[9] pulse afterward.
- btn_m and btn_enter rise together: controls[9] pulses at cycle N and controls[12] at cycle N+1, never overlapping.
- switch=10'b10_1010_0101: after 3 cycles controls[7:0]=8'hA5, controls[14:13]=2'b10, controls[8]=0, with no pulses.
- btn_enter held; reset asserted mid-debounce (count=2) for 1 cycle, asynchronously: controls=0 and active_sel=0 immediately. After release, exactly one enter pulse arrives 7 cycles later.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared front-panel definitions: selection encodings and controls-word bit map.
// The high-level mode FSM imports the same constants to decode the controls word.
package panel_pkg;

    typedef enum logic [1:0] {
        SEL_F = 2'd0,
        SEL_T = 2'd1,
        SEL_M = 2'd2
    } sel_e;

    localparam int unsigned CTL_VAL_LSB  = 0;
    localparam int unsigned CTL_VAL_MSB  = 7;
    localparam int unsigned CTL_RSVD     = 8;
    localparam int unsigned CTL_SEL_M    = 9;
    localparam int unsigned CTL_SEL_T    = 10;
    localparam int unsigned CTL_SEL_F    = 11;
    localparam int unsigned CTL_ENTER    = 12;
    localparam int unsigned CTL_MODE_LSB = 13;
    localparam int unsigned CTL_MODE_MSB = 14;
    localparam int unsigned CTL_WIDTH    = 15;

    localparam int unsigned SWITCH_WIDTH = 10;

endpackage

// File: rtl/button_debouncer.sv
// One raw button: multi-flop synchronizer, stable-count debounce and a registered
// rise strobe asserted in the cycle the debounced level goes 0->1.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   synced;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic                   level_next;

    assign synced = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
        end
    end

    // Any cycle where the synchronized input agrees with the debounced level restarts the count.
    always_comb begin
        count_next = '0;
        level_next = level;
        if (synced != level) begin
            if (count == CNT_LAST) begin
                level_next = synced;
            end else begin
                count_next = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            count <= count_next;
            level <= level_next;
            rise  <= level_next & ~level;
        end
    end

endmodule

// File: rtl/panel_control_encoder.sv
// Front-panel conditioner: debounced buttons become single-cycle select/enter
// pulses, synchronized switches feed the value and mode fields of the controls word.
module panel_control_encoder
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      btn_f,
    input  logic                      btn_t,
    input  logic                      btn_m,
    input  logic                      btn_enter,
    input  logic [SWITCH_WIDTH-1:0]   switch,
    output logic [CTL_WIDTH-1:0]      controls,
    output logic [1:0]                active_sel
);

    logic rise_f;
    logic rise_t;
    logic rise_m;
    logic rise_e;
    logic level_f;
    logic level_t;
    logic level_m;
    logic level_e;
    logic unused_levels;

    logic [SWITCH_WIDTH-1:0] sw_sync [SYNC_STAGES];
    logic [SWITCH_WIDTH-1:0] sw_level;

    logic [CTL_WIDTH-1:0] ctl_q;
    logic [CTL_WIDTH-1:0] ctl_next;
    sel_e                 active_q;
    sel_e                 active_next;
    logic                 pending_q;
    logic                 pending_next;
    logic                 any_sel;

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_f (
        .clock (clock),
        .reset (reset),
        .raw   (btn_f),
        .level (level_f),
        .rise  (rise_f)
    );

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_t (
        .clock (clock),
        .reset (reset),
        .raw   (btn_t),
        .level (level_t),
        .rise  (rise_t)
    );

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_m (
        .clock (clock),
        .reset (reset),
        .raw   (btn_m),
        .level (level_m),
        .rise  (rise_m)
    );

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_e (
        .clock (clock),
        .reset (reset),
        .raw   (btn_enter),
        .level (level_e),
        .rise  (rise_e)
    );

    assign unused_levels = ^{level_f, level_t, level_m, level_e};

    // Switches are level inputs: synchronized only, never debounced.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= '0;
            end
        end else begin
            sw_sync[0] <= switch;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= sw_sync[i-1];
            end
        end
    end

    assign sw_level = sw_sync[SYNC_STAGES-1];

    always_comb begin
        ctl_next     = '0;
        active_next  = active_q;
        pending_next = 1'b0;
        any_sel      = rise_f | rise_t | rise_m;

        ctl_next[CTL_VAL_MSB:CTL_VAL_LSB]   = sw_level[7:0];
        ctl_next[CTL_MODE_MSB:CTL_MODE_LSB] = sw_level[9:8];

        // Coincident lower-priority rises are dropped outright, not queued.
        if (rise_f) begin
            ctl_next[CTL_SEL_F] = 1'b1;
            active_next         = SEL_F;
        end else if (rise_t) begin
            ctl_next[CTL_SEL_T] = 1'b1;
            active_next         = SEL_T;
        end else if (rise_m) begin
            ctl_next[CTL_SEL_M] = 1'b1;
            active_next         = SEL_M;
        end

        // Enter yields to any select; a held-off enter collapses into one pulse.
        if (rise_e || pending_q) begin
            if (any_sel) begin
                pending_next = 1'b1;
            end else begin
                ctl_next[CTL_ENTER] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctl_q     <= '0;
            active_q  <= SEL_F;
            pending_q <= 1'b0;
        end else begin
            ctl_q     <= ctl_next;
            active_q  <= active_next;
            pending_q <= pending_next;
        end
    end

    assign controls   = ctl_q;
    assign active_sel = active_q;

endmodule

// File: tb/tb_panel_control_encoder.sv
// Directed bench for panel_control_encoder with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// press-to-pulse latency of 7 cycles, priority, enter deferral and async reset.
module tb_panel_control_encoder;

    logic        clock;
    logic        reset;
    logic        btn_f;
    logic        btn_t;
    logic        btn_m;
    logic        btn_enter;
    logic [9:0]  switch;
    logic [14:0] controls;
    logic [1:0]  active_sel;

    int checks;
    int errors;

    panel_control_encoder #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_f      (btn_f),
        .btn_t      (btn_t),
        .btn_m      (btn_m),
        .btn_enter  (btn_enter),
        .switch     (switch),
        .controls   (controls),
        .active_sel (active_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance n cycles, tallying every pulse bit seen and any illegal pulse combination.
    task automatic watch(input int n, output int npulse, output int nbad);
        npulse = 0;
        nbad   = 0;
        repeat (n) begin
            step();
            npulse += int'(controls[12]) + int'(controls[11]) + int'(controls[10]) + int'(controls[9]);
            if ((controls[12] && (controls[11:9] != 3'b000)) ||
                ($countones(controls[11:9]) > 1) || controls[8]) begin
                nbad++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_f = 1'b0; btn_t = 1'b0; btn_m = 1'b0; btn_enter = 1'b0;
        switch = '0;
        repeat (3) step();
        checks++;
        if (controls !== 15'h0000) begin
            errors++;
            $display("FAIL reset_controls: got %h expected %h", controls, 15'h0000);
        end
        checks++;
        if (active_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_active_sel: got %0d expected %0d", active_sel, 0);
        end
        reset = 1'b0;
        repeat (4) step();
        checks++;
        if (controls !== 15'h0000) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected %h", controls, 15'h0000);
        end
    endtask

    task automatic test_switches();
        switch = 10'b10_1010_0101;
        repeat (2) step();
        checks++;
        if (controls !== 15'h0000) begin
            errors++;
            $display("FAIL switch_latency_early: got %h expected %h", controls, 15'h0000);
        end
        step();
        checks++;
        if (controls !== 15'h40A5) begin
            errors++;
            $display("FAIL switch_fields: got %h expected %h", controls, 15'h40A5);
        end
    endtask

    task automatic test_bounce_f();
        int n = 0;
        int np, nb;
        for (int i = 0; i < 12; i++) begin
            btn_f = (((i / 2) % 2) == 0);
            step();
            n += int'(controls[12]) + int'(controls[11]) + int'(controls[10]) + int'(controls[9]);
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL bounce_no_pulse: got %0d pulses expected 0", n);
        end
        btn_f = 1'b1;
        watch(6, np, nb);
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL bounce_settle_early: got %0d pulses expected 0", np);
        end
        step();
        checks++;
        if (controls[12:9] !== 4'b0100) begin
            errors++;
            $display("FAIL bounce_settle_pulse: got %b expected %b", controls[12:9], 4'b0100);
        end
        checks++;
        if (active_sel !== 2'd0) begin
            errors++;
            $display("FAIL bounce_active_sel: got %0d expected 0", active_sel);
        end
        btn_f = 1'b0;
        watch(12, np, nb);
        checks++;
        if (np !== 0 || nb !== 0) begin
            errors++;
            $display("FAIL bounce_release: got %0d pulses %0d bad expected 0 0", np, nb);
        end
    endtask

    task automatic test_select_t();
        int np, nb;
        btn_t = 1'b1;
        watch(6, np, nb);
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL t_early: got %0d pulses expected 0", np);
        end
        step();
        checks++;
        if (controls[12:9] !== 4'b0010) begin
            errors++;
            $display("FAIL t_pulse: got %b expected %b", controls[12:9], 4'b0010);
        end
        checks++;
        if (active_sel !== 2'd1) begin
            errors++;
            $display("FAIL t_active_sel: got %0d expected 1", active_sel);
        end
        watch(13, np, nb);
        checks++;
        if (np !== 0 || nb !== 0) begin
            errors++;
            $display("FAIL t_hold: got %0d pulses %0d bad expected 0 0", np, nb);
        end
        btn_t = 1'b0;
        watch(12, np, nb);
        checks++;
        if (np !== 0 || active_sel !== 2'd1) begin
            errors++;
            $display("FAIL t_release: got %0d pulses sel %0d expected 0 pulses sel 1", np, active_sel);
        end
    endtask

    task automatic test_f_m_coincident();
        int np, nb;
        btn_f = 1'b1;
        btn_m = 1'b1;
        watch(6, np, nb);
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL fm_early: got %0d pulses expected 0", np);
        end
        step();
        checks++;
        if (controls[12:9] !== 4'b0100) begin
            errors++;
            $display("FAIL fm_priority: got %b expected %b", controls[12:9], 4'b0100);
        end
        checks++;
        if (active_sel !== 2'd0) begin
            errors++;
            $display("FAIL fm_active_sel: got %0d expected 0", active_sel);
        end
        watch(20, np, nb);
        checks++;
        if (np !== 0 || nb !== 0) begin
            errors++;
            $display("FAIL fm_m_dropped: got %0d pulses %0d bad expected 0 0", np, nb);
        end
        btn_f = 1'b0;
        btn_m = 1'b0;
        watch(12, np, nb);
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL fm_release: got %0d pulses expected 0", np);
        end
    endtask

    task automatic test_back_to_back();
        int np, nb;
        btn_m     = 1'b1;
        btn_enter = 1'b1;
        watch(6, np, nb);
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL me_early: got %0d pulses expected 0", np);
        end
        step();
        checks++;
        if (controls[12:9] !== 4'b0001) begin
            errors++;
            $display("FAIL me_select_first: got %b expected %b", controls[12:9], 4'b0001);
        end
        checks++;
        if (active_sel !== 2'd2) begin
            errors++;
            $display("FAIL me_active_sel: got %0d expected 2", active_sel);
        end
        step();
        checks++;
        if (controls[12:9] !== 4'b1000) begin
            errors++;
            $display("FAIL me_enter_deferred: got %b expected %b", controls[12:9], 4'b1000);
        end
        step();
        checks++;
        if (controls[12:9] !== 4'b0000) begin
            errors++;
            $display("FAIL me_enter_single: got %b expected %b", controls[12:9], 4'b0000);
        end
        watch(15, np, nb);
        btn_m     = 1'b0;
        btn_enter = 1'b0;
        watch(12, np, nb);
        checks++;
        if (np !== 0 || nb !== 0) begin
            errors++;
            $display("FAIL me_hold_release: got %0d pulses %0d bad expected 0 0", np, nb);
        end
    endtask

    task automatic test_reset_pending();
        int np, nb;
        btn_enter = 1'b1;
        repeat (4) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (controls !== 15'h0000) begin
            errors++;
            $display("FAIL async_reset_controls: got %h expected %h", controls, 15'h0000);
        end
        checks++;
        if (active_sel !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_active_sel: got %0d expected 0", active_sel);
        end
        #9;
        reset = 1'b0;
        watch(6, np, nb);
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL rst_enter_early: got %0d pulses expected 0", np);
        end
        step();
        checks++;
        if (controls !== 15'h50A5) begin
            errors++;
            $display("FAIL rst_enter_pulse: got %h expected %h", controls, 15'h50A5);
        end
        watch(15, np, nb);
        checks++;
        if (np !== 0 || nb !== 0) begin
            errors++;
            $display("FAIL rst_enter_hold: got %0d pulses %0d bad expected 0 0", np, nb);
        end
        btn_enter = 1'b0;
        watch(12, np, nb);
        checks++;
        if (np !== 0 || active_sel !== 2'd0) begin
            errors++;
            $display("FAIL rst_enter_release: got %0d pulses sel %0d expected 0 pulses sel 0", np, active_sel);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_switches();
        test_bounce_f();
        test_select_t();
        test_f_m_coincident();
        test_back_to_back();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
